// File: rtl/strobe_period_meter.sv
// strobe_period_meter: counts enable-qualified ticks between strobes
// and offers each period on a valid/ready channel. Option: STROBE_PERIOD_MATCH_EN
module strobe_period_meter #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
`ifdef STROBE_PERIOD_MATCH_EN
  input  logic [WIDTH-1:0] expected_period,
  output logic             period_mismatch,
`endif
  output logic [WIDTH-1:0] period,
  output logic             period_sat,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             drop,
  output logic             locked
);

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  localparam logic [WIDTH-1:0] ACC_MAX = '1;
  localparam logic [WIDTH-1:0] ACC_ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             acc_sat;
  logic [WIDTH-1:0] en_tick;
  logic             res_fire;
  logic             out_free;
  logic             accept;

  assign en_tick  = enable ? ACC_ONE : '0;
  assign res_fire = (state == ARMED) && strobe_in;
  assign accept   = period_valid && period_ready;
  assign out_free = !period_valid || accept;

  // Window FSM: the strobe cycle's own tick opens the next window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      acc_sat <= 1'b0;
      locked  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strobe_in) begin
            state  <= ARMED;
            acc    <= en_tick;
            locked <= 1'b1;
          end
        end
        ARMED: begin
          if (strobe_in) begin
            acc     <= en_tick;
            acc_sat <= 1'b0;
          end else if (enable) begin
            if (acc == ACC_MAX) begin
              acc_sat <= 1'b1;
            end else begin
              acc <= acc + ACC_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load when free, otherwise flag the lost result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period       <= '0;
      period_sat   <= 1'b0;
      period_valid <= 1'b0;
      drop         <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (res_fire) begin
        if (out_free) begin
          period       <= acc;
          period_sat   <= acc_sat;
          period_valid <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (accept) begin
        period_valid <= 1'b0;
      end
    end
  end

`ifdef STROBE_PERIOD_MATCH_EN
  logic res_mismatch;

  assign res_mismatch = acc_sat || (acc != expected_period);

  // Mismatch flag travels with the period it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_mismatch <= 1'b0;
    end else if (res_fire && out_free) begin
      period_mismatch <= res_mismatch;
    end
  end
`endif

endmodule
